fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Purpose
//   Instruction-fetch stage of a simple in-order pipeline. Holds the program
//   counter and drives it straight out to instruction memory. The returned
//   instruction is captured into the IF/ID pipeline register.
//
//   Next-PC priority:
//     1. branch redirect from EXE, which also flushes IF/ID
//     2. hazard stall, which holds the PC and IF/ID
//     3. sequential fetch at PC+4, wrapping at 32 bits
//
// Parameters
//   RESET_PC     PC value loaded while reset is asserted.
//
// Ports
//   clk          in   1   single clock; all state changes on its rising edge
//   rst          in   1   asynchronous, active-low reset
//   freeze       in   1   stall request from the hazard unit
//   branchTaken  in   1   redirect request from EXE
//   branchAddr   in   32  redirect target; must be word-aligned
//   instAddr     out  32  instruction-memory address (the PC register itself)
//   instIn       in   32  instruction word for instAddr, valid in the same cycle
//   pc_ID        out  32  PC+4 of the instruction held for ID
//   inst_ID      out  32  instruction held for ID
//   valid_ID     out  1   1 = inst_ID is a real instruction, 0 = bubble
//
// Optional feature (macro FETCH_PERF_CNT_EN)
//   stallCount   out  32  cycles with freeze=1 and branchTaken=0 (wraps)
//   flushCount   out  32  cycles with branchTaken=1 (wraps)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branchTaken,
    input  logic [31:0] branchAddr,
    output logic [31:0] instAddr,
    input  logic [31:0] instIn,
    output logic [31:0] pc_ID,
    output logic [31:0] inst_ID,
    output logic        valid_ID
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stallCount,
    output logic [31:0] flushCount
`endif
);

    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic [31:0] pc_id_reg;
    logic [31:0] pc_id_next;
    logic [31:0] inst_id_reg;
    logic [31:0] inst_id_next;
    logic        valid_id_reg;
    logic        valid_id_next;

    // Plain 32-bit add: 32'hFFFF_FFFC + 4 wraps to zero.
    assign pc_plus4 = pc_reg + 32'd4;

    always_comb begin
        pc_next       = pc_reg;
        pc_id_next    = pc_id_reg;
        inst_id_next  = inst_id_reg;
        valid_id_next = valid_id_reg;
        if (branchTaken) begin
            // The redirect wins over a stall: the instruction currently being
            // fetched is on the wrong path, so IF/ID becomes a bubble.
            pc_next       = branchAddr;
            pc_id_next    = 32'h0;
            inst_id_next  = 32'h0;
            valid_id_next = 1'b0;
        end else if (!freeze) begin
            pc_next       = pc_plus4;
            pc_id_next    = pc_plus4;
            inst_id_next  = instIn;
            valid_id_next = 1'b1;
        end
        // freeze alone: every register keeps its value for as long as it lasts.
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg       <= RESET_PC;
            pc_id_reg    <= 32'h0;
            inst_id_reg  <= 32'h0;
            valid_id_reg <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            pc_id_reg    <= pc_id_next;
            inst_id_reg  <= inst_id_next;
            valid_id_reg <= valid_id_next;
        end
    end

    assign instAddr = pc_reg;
    assign pc_ID    = pc_id_reg;
    assign inst_ID  = inst_id_reg;
    assign valid_ID = valid_id_reg;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] flush_cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_reg <= 32'h0;
            flush_cnt_reg <= 32'h0;
        end else begin
            if (branchTaken) begin
                flush_cnt_reg <= flush_cnt_reg + 32'd1;
            end else if (freeze) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
        end
    end

    assign stallCount = stall_cnt_reg;
    assign flushCount = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. A directed sequence exercises reset,
// sequential fetch, stalls, flushes, branch/stall collisions, asynchronous
// reset mid-stall and PC wrap; a randomized phase follows. Expected values
// come from a cycle-level reference model of the fetch rules kept here.
// Counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branchTaken;
    logic [31:0] branchAddr;
    logic [31:0] instAddr;
    logic [31:0] instIn;
    logic [31:0] pc_ID;
    logic [31:0] inst_ID;
    logic        valid_ID;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stallCount;
    logic [31:0] flushCount;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_pc_id;
    logic [31:0] m_inst_id;
    logic        m_valid;
    logic [31:0] m_stall;
    logic [31:0] m_flush;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .branchTaken (branchTaken),
        .branchAddr  (branchAddr),
        .instAddr    (instAddr),
        .instIn      (instIn),
        .pc_ID       (pc_ID),
        .inst_ID     (inst_ID),
        .valid_ID    (valid_ID)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stallCount  (stallCount),
        .flushCount  (flushCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: an address-dependent pattern so that a
    // wrong fetch address shows up as a wrong instruction word.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign instIn = imem(instAddr);

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check32({tag, ".instAddr"}, instAddr, m_pc);
        check32({tag, ".pc_ID"},    pc_ID,    m_pc_id);
        check32({tag, ".inst_ID"},  inst_ID,  m_inst_id);
        check32({tag, ".valid_ID"}, {31'h0, valid_ID}, {31'h0, m_valid});
`ifdef FETCH_PERF_CNT_EN
        check32({tag, ".stallCount"}, stallCount, m_stall);
        check32({tag, ".flushCount"}, flushCount, m_flush);
`endif
        $display("%0t %s pc=%h pc_ID=%h inst_ID=%h valid=%0d", $time, tag,
                 instAddr, pc_ID, inst_ID, valid_ID);
    endtask

    task automatic model_reset();
        m_pc      = 32'h0;
        m_pc_id   = 32'h0;
        m_inst_id = 32'h0;
        m_valid   = 1'b0;
        m_stall   = 32'h0;
        m_flush   = 32'h0;
    endtask

    // One clock cycle with the given inputs; the model applies the fetch
    // rules at the edge and all outputs are checked 1 ns later.
    task automatic cycle(input logic f, input logic b, input logic [31:0] a, input string tag);
        freeze      = f;
        branchTaken = b;
        branchAddr  = a;
        @(posedge clk);
        if (b) begin
            m_pc      = a;
            m_pc_id   = 32'h0;
            m_inst_id = 32'h0;
            m_valid   = 1'b0;
            m_flush   = m_flush + 1;
        end else if (f) begin
            m_stall   = m_stall + 1;
        end else begin
            m_inst_id = imem(m_pc);
            m_pc      = m_pc + 32'd4;
            m_pc_id   = m_pc;
            m_valid   = 1'b1;
        end
        #1;
        check_all(tag);
    endtask

    // Assert reset away from any clock edge, confirm the outputs clear at
    // once, hold it across an edge with arbitrary inputs, then release.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_all({tag, ".async"});
        freeze      = 1'($urandom);
        branchTaken = 1'($urandom);
        branchAddr  = $urandom & 32'hFFFF_FFFC;
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    logic [31:0] snap_pc_id;
    logic [31:0] snap_inst;

    initial begin
        rst         = 1'b0;
        freeze      = 1'b0;
        branchTaken = 1'b0;
        branchAddr  = 32'h0;
        model_reset();
        #3;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;
        #1;

        // Sequential fetch: PC 0 -> 4 -> 8
        cycle(1'b0, 1'b0, 32'h0, "seq1");
        check32("seq1.pc_ID_abs", pc_ID, 32'h4);
        check32("seq1.valid_abs", {31'h0, valid_ID}, 32'h1);
        cycle(1'b0, 1'b0, 32'h0, "seq2");
        check32("seq2.instAddr_abs", instAddr, 32'h8);

        // Freeze for three cycles at PC=8
        snap_pc_id = pc_ID;
        snap_inst  = inst_ID;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 32'h0, "freeze");
            check32("freeze.hold_pc", instAddr, 32'h8);
            check32("freeze.hold_pc_ID", pc_ID, snap_pc_id);
            check32("freeze.hold_inst", inst_ID, snap_inst);
        end
        cycle(1'b0, 1'b0, 32'h0, "release");
        check32("release.instAddr_abs", instAddr, 32'hC);
        cycle(1'b0, 1'b0, 32'h0, "seq3");

        // Branch at PC=16 to 0x40
        cycle(1'b0, 1'b1, 32'h40, "branch");
        check32("branch.instAddr_abs", instAddr, 32'h40);
        check32("branch.valid_abs", {31'h0, valid_ID}, 32'h0);
        cycle(1'b0, 1'b0, 32'h0, "post_branch");
        check32("post_branch.pc_ID_abs", pc_ID, 32'h44);
        check32("post_branch.inst_abs", inst_ID, imem(32'h40));

        // Branch and freeze together
        cycle(1'b1, 1'b1, 32'h100, "branch_freeze");
        check32("branch_freeze.pc_abs", instAddr, 32'h100);

        // Asynchronous reset mid-stall at PC=0x20
        cycle(1'b0, 1'b1, 32'h20, "to_20");
        cycle(1'b1, 1'b0, 32'h0, "stall_20");
        async_reset("rst_mid_stall");
        cycle(1'b0, 1'b0, 32'h0, "first_fetch");
        check32("first_fetch.pc_ID_abs", pc_ID, 32'h4);

        // PC wrap
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, "to_top");
        cycle(1'b0, 1'b0, 32'h0, "wrap");
        check32("wrap.instAddr_abs", instAddr, 32'h0);
        check32("wrap.pc_ID_abs", pc_ID, 32'h0);

        // Randomized phase
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                async_reset("rand_rst");
            end else begin
                cycle(($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2),
                      $urandom & 32'hFFFF_FFFC, "rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
